turbo_iter_sched: RTL
=====================

Name: turbo_iter_sched

Overview:
Iteration scheduler for the turbo decoder. It sequences the single shared SISO through alternating half-iterations: DEC1 uses natural order and DEC2 uses interleaved order. It counts full iterations up to MAX_ITER and stops early on a hard-decision match. A per-half-iteration watchdog guards against a hung SISO, and the block reports completion status to the decoder top.

Parameters:
MAX_ITER, 16, maximum number of full iterations (DEC1+DEC2) per frame; legal range 1..31
MIN_ITER, 2, minimum full iterations before early stop is allowed; legal range 1..MAX_ITER
ITER_W, 5, width of the iteration counter; must hold MAX_ITER
TIMEOUT, 1024, cycles allowed from siso_start_o to siso_done_i before timeout
TO_W, 10, width of the watchdog counter; must hold TIMEOUT-1

Ports:
clk_p_i  in  1  clock; all logic is on the rising edge
reset_n_i  in  1  asynchronous, active-low reset
start_i  in  1  frame start pulse; accepted only in IDLE
early_en_i  in  1  early-termination enable; sampled when start_i is accepted
abort_i  in  1  abort the current frame
siso_done_i  in  1  SISO half-iteration complete (1-cycle pulse)
hd_match_i  in  1  hard decisions unchanged vs previous iteration; qualified by siso_done_i in DEC2_RUN
siso_start_o  out  1  1-cycle pulse that launches the SISO
siso_sel_o  out  1  0 = DEC1 (natural order), 1 = DEC2 (interleaved order)
busy_o  out  1  high in every state except IDLE
done_o  out  1  1-cycle pulse at frame completion
iter_count_o  out  ITER_W  completed full iterations
early_stop_o  out  1  frame ended by early termination
timeout_o  out  1  frame ended by watchdog
aborted_o  out  1  frame ended by abort_i

Behaviour:
- Reset values: state IDLE; all outputs 0; iter_count_o = 0; watchdog = 0; latched early_en = 0.
- All outputs are registered.
- States: IDLE, DEC1_RUN, DEC1_DONE, DEC2_RUN, DEC2_DONE, FINISH.
- IDLE:
  - start_i=1 → DEC1_RUN.
  - On that edge: siso_start_o=1 for one cycle, siso_sel_o=0, iter_count_o=0, status flags cleared, early_en_i latched.
- DEC1_RUN:
  - siso_done_i=1 → DEC1_DONE.
  - Watchdog reaches TIMEOUT-1 with no done → FINISH, timeout_o=1.
- DEC1_DONE (1 cycle) → DEC2_RUN.
  - On that edge: siso_sel_o=1, siso_start_o pulses, watchdog cleared.
- DEC2_RUN:
  - siso_done_i=1 → DEC2_DONE; iter_count_o increments; hd_match_i captured.
  - Timeout handled as in DEC1_RUN.
- DEC2_DONE (1 cycle):
  - If iter_count_o == MAX_ITER → FINISH.
  - Else if early_en latched AND captured match AND iter_count_o >= MIN_ITER → FINISH, early_stop_o=1.
  - Else → DEC1_RUN with siso_sel_o=0 and a siso_start_o pulse.
  - When MAX_ITER is reached on a matching iteration, early_stop_o=0.
- FINISH (1 cycle):
  - done_o=1 → IDLE; siso_sel_o returns to 0.
  - Status flags and iter_count_o hold until the next accepted start_i.
- Latency: start_i to first siso_start_o is 1 cycle. siso_done_i to the next siso_start_o is 2 cycles.
- Watchdog:
  - Clears on every siso_start_o and counts only in RUN states.
  - siso_done_i in the same cycle as expiry: done wins, no timeout.
- abort_i in any non-IDLE state:
  - Next state FINISH; aborted_o=1; done_o pulses.
  - Takes priority over siso_done_i and timeout in the same cycle.
  - No siso_start_o is issued afterwards.
  - abort_i in IDLE is ignored.
- Ignored inputs:
  - start_i while busy_o=1.
  - siso_done_i outside RUN states.
  - hd_match_i without siso_done_i in DEC2_RUN.
- Exactly one status flag or none (normal max-iteration end) is set per frame.
- Asynchronous reset mid-frame returns to IDLE immediately, with no done_o.

Decomposition:
- Shared package turbo_pkg:
  - state encoding (3 bits);
  - SEL_NAT=0 / SEL_INT=1 constants;
  - default MAX_ITER/TIMEOUT constants, also used by the decoder top.
- Sub-module turbo_watchdog:
  - ports: clear, enable, expired;
  - parameters: TIMEOUT, TO_W.

Test Plan:
- Full run: early_en_i=0, SISO answers 5 cycles after each start → 32 siso_start_o pulses alternating sel 0/1; done_o once; iter_count_o=16; all flags 0.
- Early stop: early_en_i=1, MIN_ITER=2, hd_match_i=1 on every DEC2 done → FINISH after iteration 2; iter_count_o=2; early_stop_o=1.
- Suppression: early_en_i=1, MAX_ITER=3, match only on iteration 3 → iter_count_o=3 with early_stop_o=0. Match only on iteration 1 (MIN_ITER=2) is ignored.
- Timeout: SISO never responds in DEC2 of iteration 1 → done_o exactly TIMEOUT cycles after that siso_start_o; timeout_o=1; iter_count_o=0. Done on the expiry cycle instead gives no timeout.
- Abort: abort_i together with siso_done_i in DEC1_RUN → aborted_o=1, done_o pulse, no further siso_start_o; start_i pulses while busy are ignored.
- Reset: reset_n_i low mid-DEC2_RUN → outputs 0 immediately. A new start_i after release runs a clean frame with iter_count_o starting at 0.

Source files
------------

// File: rtl/turbo_pkg.sv
// -----------------------------------------------------------------------------
// turbo_pkg
// Shared definitions for the turbo decoder iteration scheduler and the decoder
// top: FSM state encoding, frame-end reason codes, SISO order-select constants
// and default iteration/watchdog sizing.
// -----------------------------------------------------------------------------
package turbo_pkg;

    // Default sizing, also consumed by the decoder top.
    localparam int DEF_MAX_ITER = 16;
    localparam int DEF_MIN_ITER = 2;
    localparam int DEF_ITER_W   = 5;
    localparam int DEF_TIMEOUT  = 1024;
    localparam int DEF_TO_W     = 10;

    // SISO order select: DEC1 reads in natural order, DEC2 in interleaved order.
    localparam logic SEL_NAT = 1'b0;
    localparam logic SEL_INT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEC1_RUN  = 3'd1,
        ST_DEC1_DONE = 3'd2,
        ST_DEC2_RUN  = 3'd3,
        ST_DEC2_DONE = 3'd4,
        ST_FINISH    = 3'd5
    } state_e;

    // Why a frame is entering FINISH; selects which status flag gets set.
    typedef enum logic [2:0] {
        FIN_NONE    = 3'd0,
        FIN_MAX     = 3'd1,
        FIN_EARLY   = 3'd2,
        FIN_TIMEOUT = 3'd3,
        FIN_ABORT   = 3'd4
    } fin_e;

    function automatic logic is_run(input state_e s);
        return (s == ST_DEC1_RUN) || (s == ST_DEC2_RUN);
    endfunction

endpackage

// File: rtl/turbo_watchdog.sv
// -----------------------------------------------------------------------------
// turbo_watchdog
// Per-half-iteration watchdog. Counts cycles while enabled; expired_o is high
// on the cycle the count sits at TIMEOUT-1 (i.e. TIMEOUT cycles after clear).
//   clk_p_i    : clock
//   reset_n_i  : asynchronous active-low reset
//   clear_i    : restart the count at zero (SISO launch)
//   enable_i   : count this cycle (a RUN state is active)
//   expired_o  : time budget used up while enabled
// -----------------------------------------------------------------------------
module turbo_watchdog #(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 10
) (
    input  logic clk_p_i,
    input  logic reset_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [TO_W-1:0] cnt_q, cnt_d;

    assign expired_o = enable_i && (cnt_q == TO_W'(TIMEOUT - 1));

    // NOTE: cnt_d gets a default before any branch so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/turbo_iter_sched.sv
// -----------------------------------------------------------------------------
// turbo_iter_sched
// Sequences the shared SISO through alternating DEC1 (natural order) and DEC2
// (interleaved order) half-iterations, counts full iterations up to MAX_ITER,
// stops early on a hard-decision match, and reports the frame-end reason.
//   clk_p_i, reset_n_i   : clock, asynchronous active-low reset
//   start_i              : frame start (accepted only in IDLE)
//   early_en_i           : early-termination enable, latched at start
//   abort_i              : abort the running frame
//   siso_done_i          : SISO half-iteration complete pulse
//   hd_match_i           : hard decisions stable, qualified by DEC2 done
//   siso_start_o         : SISO launch pulse
//   siso_sel_o           : 0 = DEC1 / natural, 1 = DEC2 / interleaved
//   busy_o, done_o       : frame in progress / frame complete pulse
//   iter_count_o         : completed full iterations
//   early_stop_o, timeout_o, aborted_o : frame-end reason (at most one set)
// All outputs are registered.
// -----------------------------------------------------------------------------
module turbo_iter_sched
    import turbo_pkg::*;
#(
    parameter int MAX_ITER = DEF_MAX_ITER,
    parameter int MIN_ITER = DEF_MIN_ITER,
    parameter int ITER_W   = DEF_ITER_W,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int TO_W     = DEF_TO_W
) (
    input  logic              clk_p_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic              early_en_i,
    input  logic              abort_i,
    input  logic              siso_done_i,
    input  logic              hd_match_i,
    output logic              siso_start_o,
    output logic              siso_sel_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ITER_W-1:0] iter_count_o,
    output logic              early_stop_o,
    output logic              timeout_o,
    output logic              aborted_o
);

    state_e            state_q, state_d;
    fin_e              fin_d;
    logic              wd_expired;

    logic              siso_start_q, siso_start_d;
    logic              siso_sel_q, siso_sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              early_stop_q, early_stop_d;
    logic              timeout_q, timeout_d;
    logic              aborted_q, aborted_d;
    logic              early_en_q, early_en_d;
    logic              match_q, match_d;

    logic              start_accept;
    logic              dec2_complete;

    turbo_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk_p_i   (clk_p_i),
        .reset_n_i (reset_n_i),
        .clear_i   (siso_start_d),
        .enable_i  (is_run(state_q)),
        .expired_o (wd_expired)
    );

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        fin_d   = FIN_NONE;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_DEC1_RUN;
            end
            ST_DEC1_RUN, ST_DEC2_RUN: begin
                // A done arriving on the expiry cycle wins over the watchdog.
                if (siso_done_i) begin
                    state_d = (state_q == ST_DEC1_RUN) ? ST_DEC1_DONE : ST_DEC2_DONE;
                end else if (wd_expired) begin
                    state_d = ST_FINISH;
                    fin_d   = FIN_TIMEOUT;
                end
            end
            ST_DEC1_DONE: state_d = ST_DEC2_RUN;
            ST_DEC2_DONE: begin
                // Reaching MAX_ITER is a normal end even if decisions matched.
                if (iter_q == ITER_W'(MAX_ITER)) begin
                    state_d = ST_FINISH;
                    fin_d   = FIN_MAX;
                end else if (early_en_q && match_q && (iter_q >= ITER_W'(MIN_ITER))) begin
                    state_d = ST_FINISH;
                    fin_d   = FIN_EARLY;
                end else begin
                    state_d = ST_DEC1_RUN;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        // Abort overrides done and timeout. FINISH is excluded: that frame has
        // already ended and must not report a second reason or a second done.
        if (abort_i && (state_q != ST_IDLE) && (state_q != ST_FINISH)) begin
            state_d = ST_FINISH;
            fin_d   = FIN_ABORT;
        end
    end

    // ---------------- output / datapath next values ----------------
    always_comb begin
        start_accept  = (state_q == ST_IDLE) && start_i;
        dec2_complete = (state_q == ST_DEC2_RUN) && (state_d == ST_DEC2_DONE);

        siso_start_d  = is_run(state_d) && (state_d != state_q);
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_FINISH);

        siso_sel_d = siso_sel_q;
        if (state_d == ST_DEC2_RUN) begin
            siso_sel_d = SEL_INT;
        end else if ((state_d == ST_DEC1_RUN) || (state_d == ST_IDLE)) begin
            siso_sel_d = SEL_NAT;
        end

        iter_d       = iter_q;
        match_d      = match_q;
        early_en_d   = early_en_q;
        early_stop_d = early_stop_q;
        timeout_d    = timeout_q;
        aborted_d    = aborted_q;

        if (start_accept) begin
            iter_d       = '0;
            match_d      = 1'b0;
            early_en_d   = early_en_i;
            early_stop_d = 1'b0;
            timeout_d    = 1'b0;
            aborted_d    = 1'b0;
        end else if (dec2_complete) begin
            iter_d  = iter_q + ITER_W'(1);
            match_d = hd_match_i;
        end

        case (fin_d)
            FIN_EARLY:   early_stop_d = 1'b1;
            FIN_TIMEOUT: timeout_d    = 1'b1;
            FIN_ABORT:   aborted_d    = 1'b1;
            default:     ;
        endcase
    end

    // ---------------- state and output registers ----------------
    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            siso_start_q <= 1'b0;
            siso_sel_q   <= SEL_NAT;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            iter_q       <= '0;
            early_stop_q <= 1'b0;
            timeout_q    <= 1'b0;
            aborted_q    <= 1'b0;
            early_en_q   <= 1'b0;
            match_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            siso_start_q <= siso_start_d;
            siso_sel_q   <= siso_sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            iter_q       <= iter_d;
            early_stop_q <= early_stop_d;
            timeout_q    <= timeout_d;
            aborted_q    <= aborted_d;
            early_en_q   <= early_en_d;
            match_q      <= match_d;
        end
    end

    assign siso_start_o = siso_start_q;
    assign siso_sel_o   = siso_sel_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign iter_count_o = iter_q;
    assign early_stop_o = early_stop_q;
    assign timeout_o    = timeout_q;
    assign aborted_o    = aborted_q;

endmodule
